// File: rtl/axis_skid_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axis_skid_pkg                                              |
// | Description : Shared stage state encoding and sizing helper for the      |
// |               axis_skid_pipe family.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package axis_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Counter width able to represent 0 .. 2*stages inclusive.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axis_skid_stage                                            |
// | Description : One full-throughput 2-entry skid stage (output reg + skid  |
// |               reg); ready and valid are decoded from state only.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module axis_skid_stage
  import axis_skid_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PAYLOAD_WIDTH-1:0] out_payload
);

  stage_state_e             r_state;
  stage_state_e             w_state_next;
  logic [PAYLOAD_WIDTH-1:0] r_out;
  logic [PAYLOAD_WIDTH-1:0] r_skid;
  logic                     w_in_fire;
  logic                     w_out_fire;
  logic                     w_load_out_from_in;
  logic                     w_load_out_from_skid;
  logic                     w_load_skid;

  assign in_ready    = (r_state != FULL);
  assign out_valid   = (r_state != EMPTY);
  assign out_payload = r_out;
  assign w_in_fire   = in_valid & in_ready;
  assign w_out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_load_out_from_in   = 1'b0;
    w_load_out_from_skid = 1'b0;
    w_load_skid          = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_state_next       = BUSY;
          w_load_out_from_in = 1'b1;
        end
      end
      BUSY: begin
        case ({w_in_fire, w_out_fire})
          2'b10: begin
            w_state_next = FULL;
            w_load_skid  = 1'b1;
          end
          2'b01: begin
            w_state_next = EMPTY;
          end
          2'b11: begin
            w_load_out_from_in = 1'b1;
          end
          default: begin
          end
        endcase
      end
      FULL: begin
        // Upstream is held off here, so only the drain direction can move.
        if (w_out_fire) begin
          w_state_next         = BUSY;
          w_load_out_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_out_from_in) begin
        r_out <= in_payload;
      end else if (w_load_out_from_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_payload;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_skid_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axis_skid_pipe                                             |
// | Description : STAGES chained AXI4-Stream skid stages, 2*STAGES beats of  |
// |               capacity. Optional occupancy counter enabled by macro      |
// |               AXIS_SKID_PIPE_OCCUPANCY_EN (tied to 0 otherwise).         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module axis_skid_pipe
  import axis_skid_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int USER_WIDTH = 1,
  parameter  int STAGES     = 2,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tlast,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [occ_width(STAGES)-1:0]  occupancy
);

  localparam int PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
  localparam int OCC_WIDTH     = occ_width(STAGES);

  logic                     r_alive;
  logic                     w_valid   [STAGES+1];
  logic                     w_ready   [STAGES+1];
  logic [PAYLOAD_WIDTH-1:0] w_payload [STAGES+1];

  // Keeps upstream ready low while reset is applied and through the reset cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  assign w_valid[0]   = s_axis_tvalid & r_alive;
  assign w_payload[0] = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
  assign s_axis_tready = w_ready[0] & r_alive;

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
      axis_skid_stage #(
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
      ) u_stage (
        .clk         (aclk),
        .rst         (areset),
        .in_valid    (w_valid[g]),
        .in_ready    (w_ready[g]),
        .in_payload  (w_payload[g]),
        .out_valid   (w_valid[g+1]),
        .out_ready   (w_ready[g+1]),
        .out_payload (w_payload[g+1])
      );
    end
  endgenerate

  assign m_axis_tvalid      = w_valid[STAGES];
  assign w_ready[STAGES]    = m_axis_tready;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = w_payload[STAGES];

`ifdef AXIS_SKID_PIPE_OCCUPANCY_EN
  logic [OCC_WIDTH-1:0] r_occ;
  logic                 w_s_fire;
  logic                 w_m_fire;

  assign w_s_fire = s_axis_tvalid & s_axis_tready;
  assign w_m_fire = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_occ <= '0;
    end else begin
      case ({w_s_fire, w_m_fire})
        2'b10:   r_occ <= r_occ + OCC_WIDTH'(1);
        2'b01:   r_occ <= r_occ - OCC_WIDTH'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occupancy = r_occ;
`else
  assign occupancy = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_skid_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_axis_skid_pipe                                          |
// | Description : Self-checking bench for axis_skid_pipe: queue scoreboard   |
// |               compared every cycle plus directed literal expectations.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_axis_skid_pipe;

  localparam int DW  = 8;
  localparam int UW  = 1;
  localparam int ST  = 2;
  localparam int KW  = DW / 8;
  localparam int OW  = $clog2(2 * ST + 1);
  localparam int PW  = DW + KW + 1 + UW;
  localparam int CAP = 2 * ST;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic [UW-1:0] s_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic [OW-1:0] occupancy;

  always #5 aclk = ~aclk;

  axis_skid_pipe #(
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .STAGES     (ST)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .occupancy     (occupancy)
  );

  int            errors = 0;
  int            checks = 0;
  logic [PW-1:0] model_q[$];
  int            phase = 0;
  int            m_mode = 0;
  int            cyc = 0;
  bit            last_rst = 1'b1;
  bit            last_rst_d = 1'b1;
  bit            prev_stall = 1'b0;
  logic [PW-1:0] prev_payload = '0;
  int            s_cnt = 0, m_cnt = 0, first_s = 0, first_m = 0, last_m = 0;
  int            tlast_cnt = 0;
  logic [7:0]    tlast_data = 8'h00;
  logic [7:0]    first_data = 8'h00;
  bit            got_first = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic int exp_occ(input int resident);
`ifdef AXIS_SKID_PIPE_OCCUPANCY_EN
    return resident;
`else
    return 0;
`endif
  endfunction

  // Compare process: model queue holds beats accepted and not yet delivered.
  always @(negedge aclk) begin
    logic [PW-1:0] act;
    bit            s_fire;
    bit            m_fire;
    act = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    cyc++;
    if (last_rst) begin
      model_q.delete();
      prev_stall = 1'b0;
      check("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
      check("rst_s_ready", 32'(s_axis_tready), 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_payload", 32'(act), 32'd0);
    end else begin
      if (last_rst_d) check("ready_after_release", 32'(s_axis_tready), 32'd1);
      check("occupancy", 32'(occupancy), 32'(exp_occ(model_q.size())));
      if (m_axis_tvalid) begin
        if (model_q.size() == 0) check("spurious_beat", 32'(m_axis_tvalid), 32'd0);
        else                     check("payload", 32'(act), 32'(model_q[0]));
      end
      if (model_q.size() == CAP) check("ready_when_full", 32'(s_axis_tready), 32'd0);
      if (model_q.size() <= ST)  check("ready_when_not_backed_up", 32'(s_axis_tready), 32'd1);
      if (prev_stall) begin
        check("stall_valid_held", 32'(m_axis_tvalid), 32'd1);
        check("stall_payload_held", 32'(act), 32'(prev_payload));
      end
    end
    s_fire       = s_axis_tvalid && s_axis_tready;
    m_fire       = m_axis_tvalid && m_axis_tready;
    prev_stall   = m_axis_tvalid && !m_axis_tready && !areset;
    prev_payload = act;
    if (!areset) begin
      if (m_fire && model_q.size() > 0) begin
        void'(model_q.pop_front());
        if (phase == 1) begin
          if (m_cnt == 0) first_m = cyc;
          last_m = cyc;
          m_cnt++;
        end
        if (phase == 3 && m_axis_tlast) begin
          tlast_cnt++;
          tlast_data = m_axis_tdata;
        end
        if (phase == 5 && !got_first) begin
          got_first  = 1'b1;
          first_data = m_axis_tdata;
        end
      end
      if (s_fire) begin
        model_q.push_back({s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser});
        if (phase == 1) begin
          if (s_cnt == 0) first_s = cyc;
          s_cnt++;
        end
      end
    end
    last_rst_d = last_rst;
    last_rst   = areset;
  end

  task automatic drive_mready();
    case (m_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'b0;
      default: m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic step(output bit fired);
    drive_mready();
    @(negedge aclk);
    fired = s_axis_tvalid && s_axis_tready;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    bit f;
    s_axis_tvalid = 1'b0;
    repeat (n) step(f);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l, input logic u,
                           input int gap_pct);
    bit f;
    int waited;
    f = 1'b0;
    waited = 0;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    while (!f) begin
      step(f);
      waited++;
      if (!f && waited > 200) begin
        timeout_fail("send_timeout");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    s_axis_tvalid = 1'b0;
    while ((model_q.size() != 0 || m_axis_tvalid) && t < 100) begin
      idle(1);
      t++;
    end
    if (t >= 100) timeout_fail("drain_timeout");
  endtask

  initial begin
    bit   f;
    int   t;
    logic [7:0] d;
    areset        = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    repeat (3) step(f);
    areset = 1'b0;

    // Continuous stream 0..99 with downstream always ready.
    phase  = 1;
    m_mode = 0;
    for (int i = 0; i < 100; i++) send_beat(8'(i), 1'b0, 1'b0, 1'b0, 0);
    t = 0;
    while (m_cnt < 100 && t < 30) begin
      idle(1);
      t++;
    end
    check("stream_beats", 32'(m_cnt), 32'd100);
    check("stream_latency", 32'(first_m - first_s), 32'(ST));
    check("stream_no_bubbles", 32'(last_m - first_m), 32'd99);
    drain();

    // Backpressure mid-stream.
    phase = 2;
    d = 8'd100;
    for (int i = 0; i < 10; i++) begin
      send_beat(d, 1'b0, 1'b0, 1'b0, 0);
      d++;
    end
    m_mode = 1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    for (int c = 0; c < 4; c++) begin
      step(f);
      if (f) begin
        d++;
        s_axis_tdata = d;
      end
    end
    check("bp_resident", 32'(model_q.size()), 32'd4);
    check("bp_s_ready", 32'(s_axis_tready), 32'd0);
    check("bp_m_valid", 32'(m_axis_tvalid), 32'd1);
    check("bp_occupancy", 32'(occupancy), 32'(exp_occ(4)));
    m_mode = 0;
    while (d < 8'd140) begin
      send_beat(d, 1'b0, 1'b0, 1'b0, 0);
      d++;
    end
    drain();

    // Upstream gap: pipe must drain and stay quiet.
    phase = 4;
    for (int i = 0; i < 5; i++) send_beat(8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 0);
    idle(9);
    check("gap_m_valid", 32'(m_axis_tvalid), 32'd0);
    check("gap_occupancy", 32'(occupancy), 32'd0);
    check("gap_resident", 32'(model_q.size()), 32'd0);

    // Sideband marks only on beat 7, random downstream stalls.
    phase  = 3;
    m_mode = 2;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] kv;
      kv = 8'h0F;
      send_beat(8'(8'h40 + i), (i == 7) ? kv[KW-1:0] : 1'b0, i == 7, i == 7, 30);
    end
    drain();
    check("tlast_count", 32'(tlast_cnt), 32'd1);
    check("tlast_beat", 32'(tlast_data), 32'h47);

    // Randomized traffic.
    phase = 0;
    for (int i = 0; i < 300; i++) begin
      send_beat(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 25);
    end
    drain();

    // Reset while stalled full.
    m_mode = 1;
    d = 8'h80;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    for (int c = 0; c < 8; c++) begin
      step(f);
      if (f) begin
        d++;
        s_axis_tdata = d;
      end
    end
    check("prerst_resident", 32'(model_q.size()), 32'd4);
    check("prerst_occupancy", 32'(occupancy), 32'(exp_occ(4)));
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    step(f);
    areset = 1'b0;
    phase  = 5;
    m_mode = 0;
    for (int i = 0; i < 8; i++) send_beat(8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, 0);
    drain();
    check("post_reset_seen", 32'(got_first), 32'd1);
    check("post_reset_first", 32'(first_data), 32'hA0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
